// File: rtl/alu4_nibble_seq.sv
// Nibble-serial ALU sequencer: feeds a DATA_WIDTH command through an external
// 4-bit ALU stage one nibble per clock, chaining carry and accumulating the zero flag.
module alu4_nibble_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    input  logic                  cmd_cin,
    input  logic                  cmd_binv,
    input  logic [1:0]            cmd_op,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_s,
    output logic                  res_c,
    output logic                  res_zero,
    output logic                  res_ovf,
    output logic [3:0]            alu_a,
    output logic [3:0]            alu_b,
    output logic                  alu_y,
    output logic                  alu_binv,
    output logic [1:0]            alu_op,
    input  logic [3:0]            alu_s,
    input  logic                  alu_c,
    input  logic                  alu_zero,
    input  logic                  alu_ovf,
    output logic [1:0]            dbg_state
);

    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Handshakes: a transfer happens on a rising clk edge where ena, valid and
    // ready are all high; valid never waits on ready.

    logic [1:0]            state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  cin_q, cin_d;
    logic                  binv_q, binv_d;
    logic [1:0]            op_q, op_d;
    logic                  carry_q, carry_d;
    logic                  zero_acc_q, zero_acc_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] work_q, work_d;
    logic [DATA_WIDTH-1:0] res_s_q, res_s_d;
    logic                  res_c_q, res_c_d;
    logic                  res_zero_q, res_zero_d;

    always_comb begin
        alu_a    = 4'd0;
        alu_b    = 4'd0;
        alu_y    = 1'b0;
        alu_binv = 1'b0;
        alu_op   = 2'd0;
        if (state_q == S_EXEC) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (k_q == KW'(i)) begin
                    alu_a = a_q[4*i +: 4];
                    alu_b = b_q[4*i +: 4];
                end
            end
            alu_y    = (k_q == '0) ? cin_q : carry_q;
            alu_binv = binv_q;
            alu_op   = op_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        binv_d     = binv_q;
        op_d       = op_q;
        carry_d    = carry_q;
        zero_acc_d = zero_acc_q;
        ovf_d      = ovf_q;
        work_d     = work_q;
        res_s_d    = res_s_q;
        res_c_d    = res_c_q;
        res_zero_d = res_zero_q;
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        a_d        = cmd_a;
                        b_d        = cmd_b;
                        cin_d      = cmd_cin;
                        binv_d     = cmd_binv;
                        op_d       = cmd_op;
                        k_d        = '0;
                        zero_acc_d = 1'b1;
                        state_d    = S_EXEC;
                    end
                end
                S_EXEC: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (k_q == KW'(i)) work_d[4*i +: 4] = alu_s;
                    end
                    carry_d    = alu_c;
                    zero_acc_d = zero_acc_q & alu_zero;
                    if (k_q == K_LAST) begin
                        // Published copies stay put while the next command runs.
                        ovf_d      = alu_ovf;
                        res_s_d    = work_d;
                        res_c_d    = alu_c;
                        res_zero_d = zero_acc_q & alu_zero;
                        state_d    = S_DONE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                S_DONE: begin
                    if (res_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            binv_q     <= 1'b0;
            op_q       <= 2'd0;
            carry_q    <= 1'b0;
            zero_acc_q <= 1'b1;
            ovf_q      <= 1'b0;
            work_q     <= '0;
            res_s_q    <= '0;
            res_c_q    <= 1'b0;
            res_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            binv_q     <= binv_d;
            op_q       <= op_d;
            carry_q    <= carry_d;
            zero_acc_q <= zero_acc_d;
            ovf_q      <= ovf_d;
            work_q     <= work_d;
            res_s_q    <= res_s_d;
            res_c_q    <= res_c_d;
            res_zero_q <= res_zero_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign res_s     = res_s_q;
    assign res_c     = res_c_q;
    assign res_zero  = res_zero_q;
    assign res_ovf   = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu4_nibble_seq.sv
// Directed bench for alu4_nibble_seq with a behavioural 4-bit ALU stage model.
module tb_alu4_nibble_seq;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic          cmd_cin = 1'b0;
    logic          cmd_binv = 1'b0;
    logic [1:0]    cmd_op = 2'd0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_s;
    logic          res_c, res_zero, res_ovf;
    logic [3:0]    alu_a, alu_b, alu_s;
    logic          alu_y, alu_binv, alu_c, alu_zero, alu_ovf;
    logic [1:0]    alu_op, dbg_state;

    int checks = 0;
    int failures = 0;
    logic [DW+2:0] exp_q[$];

    always #5 clk = ~clk;

    alu4_nibble_seq #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_binv(cmd_binv), .cmd_op(cmd_op),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_s(res_s), .res_c(res_c), .res_zero(res_zero), .res_ovf(res_ovf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_binv(alu_binv), .alu_op(alu_op),
        .alu_s(alu_s), .alu_c(alu_c), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .dbg_state(dbg_state)
    );

    // 4-bit ALU stage model: SUM/OR/AND/XOR on (B or ~B); carry/ovf only for SUM.
    logic [3:0] m_bb, m_s;
    logic [4:0] m_sum;
    always_comb begin
        m_bb  = alu_binv ? ~alu_b : alu_b;
        m_sum = {1'b0, alu_a} + {1'b0, m_bb} + {4'd0, alu_y};
        m_s   = 4'd0;
        alu_c = 1'b0;
        alu_ovf = 1'b0;
        case (alu_op)
            2'd0: begin
                m_s     = m_sum[3:0];
                alu_c   = m_sum[4];
                alu_ovf = (alu_a[3] == m_bb[3]) && (m_sum[3] != alu_a[3]);
            end
            2'd1: m_s = alu_a | m_bb;
            2'd2: m_s = alu_a & m_bb;
            default: m_s = alu_a ^ m_bb;
        endcase
        alu_s    = m_s;
        alu_zero = (m_s == 4'd0);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_res(input logic [DW-1:0] s, input logic c, input logic z, input logic o);
        exp_q.push_back({o, z, c, s});
    endtask

    // Offers one command at a negedge; returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic cin, input logic binv, input logic [1:0] op);
        @(negedge clk);
        check_eq("cmd_ready_idle", cmd_ready, 1);
        cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_binv = binv; cmd_op = op;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("state_exec", dbg_state, 1);
        check_eq("res_valid_exec", res_valid, 0);
    endtask

    task automatic wait_result(output int cnt);
        cnt = 0;
        while (!res_valid && cnt < 64) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        check_eq("res_valid_seen", res_valid, 1);
    endtask

    task automatic check_result();
        logic [DW+2:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check_eq("res_s", res_s, e[DW-1:0]);
        check_eq("res_c", res_c, e[DW]);
        check_eq("res_zero", res_zero, e[DW+1]);
        check_eq("res_ovf", res_ovf, e[DW+2]);
        check_eq("cmd_ready_done", cmd_ready, 0);
    endtask

    task automatic consume(input logic [DW-1:0] s);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("state_idle", dbg_state, 0);
        check_eq("res_valid_low", res_valid, 0);
        check_eq("cmd_ready_back", cmd_ready, 1);
        check_eq("res_s_retained", res_s, s);
    endtask

    task automatic full_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin,
                           input logic binv, input logic [1:0] op, input logic [DW-1:0] s,
                           input logic c, input logic z, input logic o);
        int cnt;
        expect_res(s, c, z, o);
        send_cmd(a, b, cin, binv, op);
        wait_result(cnt);
        check_eq("latency", cnt, DW / 4);
        check_result();
        consume(s);
    endtask

    initial begin
        int cnt;
        #12;
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_s", res_s, 0);
        check_eq("rst_res_flags", {res_c, res_zero, res_ovf}, 0);
        check_eq("rst_alu_out", {alu_a, alu_b, alu_y, alu_binv, alu_op}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Signed-overflow add.
        full_op(8'h7F, 8'h01, 1'b0, 1'b0, 2'd0, 8'h80, 1'b0, 1'b0, 1'b1);

        // Carry chain: carry from nibble 0 must appear on alu_y at nibble 1.
        expect_res(8'h00, 1'b1, 1'b1, 1'b0);
        send_cmd(8'hFF, 8'h01, 1'b0, 1'b0, 2'd0);
        check_eq("k0_alu_y", alu_y, 0);
        check_eq("k0_alu_a", alu_a, 4'hF);
        check_eq("k0_alu_b", alu_b, 4'h1);
        @(posedge clk);
        @(negedge clk);
        check_eq("k1_alu_y", alu_y, 1);
        check_eq("k1_alu_a", alu_a, 4'hF);
        check_eq("k1_alu_b", alu_b, 4'h0);
        wait_result(cnt);
        check_eq("latency_tail", cnt, 1);
        check_eq("alu_idle_done", {alu_a, alu_b, alu_y, alu_binv, alu_op}, 0);
        check_result();
        consume(8'h00);

        // Subtraction via binv + cin.
        full_op(8'h05, 8'h05, 1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0);
        full_op(8'h03, 8'h05, 1'b1, 1'b1, 2'd0, 8'hFE, 1'b0, 1'b0, 1'b0);
        full_op(8'hA5, 8'h0F, 1'b0, 1'b0, 2'd3, 8'hAA, 1'b0, 1'b0, 1'b0);
        full_op(8'h50, 8'h0A, 1'b0, 1'b0, 2'd1, 8'h5A, 1'b0, 1'b0, 1'b0);

        // Backpressure with a stray command offered while DONE.
        expect_res(8'h30, 1'b0, 1'b0, 1'b0);
        send_cmd(8'hF0, 8'h3C, 1'b0, 1'b0, 2'd2);
        wait_result(cnt);
        check_result();
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_a = 8'h11; cmd_b = 8'h22; cmd_op = 2'd0;
            @(posedge clk);
            @(negedge clk);
            check_eq("bp_res_valid", res_valid, 1);
            check_eq("bp_res_s", res_s, 8'h30);
            check_eq("bp_cmd_ready", cmd_ready, 0);
            check_eq("bp_state", dbg_state, 2);
        end
        cmd_valid = 1'b0;
        consume(8'h30);

        // Reset mid-EXEC after edge 1.
        send_cmd(8'h12, 8'h34, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rx_cmd_ready", cmd_ready, 1);
        check_eq("rx_res_valid", res_valid, 0);
        check_eq("rx_res_s", res_s, 0);
        check_eq("rx_alu_a", alu_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        full_op(8'h12, 8'h34, 1'b0, 1'b0, 2'd0, 8'h46, 1'b0, 1'b0, 1'b0);

        // Reset while holding a result in DONE.
        send_cmd(8'h7F, 8'h01, 1'b0, 1'b0, 2'd0);
        wait_result(cnt);
        rst_n = 1'b0;
        #1;
        check_eq("rd_res_valid", res_valid, 0);
        check_eq("rd_res_s", res_s, 0);
        check_eq("rd_res_ovf", res_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ena low for 3 cycles at k=1.
        expect_res(8'h80, 1'b0, 1'b0, 1'b1);
        send_cmd(8'h7F, 8'h01, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        @(negedge clk);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("ena_state", dbg_state, 1);
            check_eq("ena_alu_a", alu_a, 4'h7);
            check_eq("ena_alu_y", alu_y, 1);
            check_eq("ena_res_valid", res_valid, 0);
        end
        ena = 1'b1;
        wait_result(cnt);
        check_eq("ena_latency", 1 + 3 + cnt, DW / 4 + 3);
        check_result();
        consume(8'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
